// File: rtl/mult_add_pkg.sv
// rtl/mult_add_pkg.sv - shared types and defaults for the shift-add multiply-accumulate unit
package mult_add_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_add.sv
// rtl/mult_add.sv - sequential shift-add unit computing A*B+C, one multiplier bit per cycle
module mult_add
  import mult_add_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_multiplicand,
  input  logic [W-1:0]   i_multiplier,
  input  logic [W-1:0]   i_addend,
  output logic           o_ready,
  output logic           o_done,
  output logic [2*W-1:0] o_result
);

  localparam int CW = $clog2(W + 1);

  state_t          state;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  a_sh;
  logic [W-1:0]    b_sh;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc_next;

  // The addend seeds the accumulator, so the final partial-product sum already includes C.
  assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
  assign o_ready  = (state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            acc   <= {{W{1'b0}}, i_addend};
            a_sh  <= {{W{1'b0}}, i_multiplicand};
            b_sh  <= i_multiplier;
            cnt   <= CW'(W);
            state <= OP;
          end
        end
        OP: begin
          acc  <= acc_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt - 1'b1;
          // Fixed W iterations: no early exit when the remaining multiplier bits are zero.
          if (cnt == CW'(1)) begin
            o_result <= acc_next;
            o_done   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
